// File: rtl/jtopl_slot_div.sv
// Operator-slot clock divider: cenop every div_sel+1 cen cycles, slot walks 0..OPCOUNT-1, cenfrm on frame wrap.
// Optional freeze input 'hold' when JTOPL_DIV_HOLD_EN is defined; the default build has no hold port.
module jtopl_slot_div #(
  parameter int DIVW    = 3,
  parameter int OPCOUNT = 18,
  parameter int SLOTW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [DIVW-1:0]  div_sel,
`ifdef JTOPL_DIV_HOLD_EN
  input  logic             hold,
`endif
  output logic             cenop,
  output logic             zero,
  output logic [SLOTW-1:0] slot,
  output logic             cenfrm
);

  localparam logic [SLOTW-1:0] LAST = SLOTW'(OPCOUNT - 1);

  logic [DIVW-1:0] cnt;
  logic [DIVW-1:0] div_q;
  logic            run;
  logic            adv;
  logic            match;
  logic            last;

`ifdef JTOPL_DIV_HOLD_EN
  assign run = ~hold;
`else
  assign run = 1'b1;
`endif

  assign adv   = cen & run;
  assign match = (cnt == div_q);
  assign last  = (slot == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      div_q  <= div_sel;
      slot   <= '0;
      zero   <= 1'b0;
      cenop  <= 1'b0;
      cenfrm <= 1'b0;
    end else begin
      cenop  <= adv & match;
      cenfrm <= adv & match & last;
      if (adv) begin
        cnt <= match ? '0 : cnt + DIVW'(1);
        // Ratio only changes at the frame boundary, so a frame never mixes spacings.
        if (match && last)
          div_q <= div_sel;
      end
      if (cenop && run) begin
        slot <= last ? '0 : slot + SLOTW'(1);
        zero <= last;
      end
    end
  end

endmodule

// File: tb/tb_jtopl_slot_div.sv
// Directed bench for jtopl_slot_div: vector table for reset/first slots, then multi-cycle period sequences.
module tb_jtopl_slot_div;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen;
  logic [2:0] div_sel;
  logic       cenop;
  logic       zero;
  logic [4:0] slot;
  logic       cenfrm;
`ifdef JTOPL_DIV_HOLD_EN
  logic       hold = 1'b0;
`endif

  jtopl_slot_div dut (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .div_sel (div_sel),
`ifdef JTOPL_DIV_HOLD_EN
    .hold    (hold),
`endif
    .cenop   (cenop),
    .zero    (zero),
    .slot    (slot),
    .cenfrm  (cenfrm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       cen;
    logic [2:0] div_sel;
    logic       cenop;
    logic [4:0] slot;
    logic       zero;
    logic       cenfrm;
  } vec_t;

  vec_t tv[16];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic prev_zero  = 1'b0;
  logic prev_cenop = 1'b0;
  int   dbl_cenop  = 0;
  int   q_op[$];
  int   q_frm[$];
  int   q_frm_slot[$];
  int   q_zr[$];
  int   q_zf[$];
  int   tmp[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clk edge, outputs sampled 1 time unit later; records output events by cycle index.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cenop) q_op.push_back(cyc);
    if (cenop && prev_cenop) dbl_cenop++;
    if (cenfrm) begin
      q_frm.push_back(cyc);
      q_frm_slot.push_back(int'(slot));
    end
    if (zero && !prev_zero) q_zr.push_back(cyc);
    if (!zero && prev_zero) q_zf.push_back(cyc);
    prev_zero  = zero;
    prev_cenop = cenop;
  endtask

  task automatic clear();
    cyc = 0;
    dbl_cenop = 0;
    q_op.delete(); q_frm.delete(); q_frm_slot.delete(); q_zr.delete(); q_zf.delete();
  endtask

  task automatic do_reset(input logic [2:0] ds);
    rst = 1'b1; cen = 1'b1; div_sel = ds;
    step();
    rst = 1'b0;
    clear();
  endtask

  // Checks every gap between consecutive entries of tmp.
  task automatic chk_iv(input string nm, input int exp);
    chk({nm, "_n"}, int'(tmp.size() >= 2), 1);
    for (int i = 1; i < tmp.size(); i++)
      chk(nm, tmp[i] - tmp[i-1], exp);
  endtask

  task automatic wait_slot(input int target);
    int n = 0;
    while (int'(slot) != target && n < 300) begin
      step();
      n++;
    end
    chk("wait_slot", int'(slot), target);
  endtask

  function automatic vec_t mk(input logic r, input logic c, input logic [2:0] d,
                              input logic op, input logic [4:0] s);
    vec_t v;
    v.rst = r; v.cen = c; v.div_sel = d;
    v.cenop = op; v.slot = s; v.zero = 1'b0; v.cenfrm = 1'b0;
    return v;
  endfunction

  initial begin
    int n;
    int f;
    int mx;
    int bad;
    int prv;
    rst = 1'b1; cen = 1'b0; div_sel = 3'd0;

    // Divide-by-2 walk with cen gaps, mid-run reset switching to divide-by-1.
    tv[0]  = mk(1, 1, 1, 0, 0);
    tv[1]  = mk(0, 1, 1, 0, 0);
    tv[2]  = mk(0, 1, 1, 1, 0);
    tv[3]  = mk(0, 1, 1, 0, 1);
    tv[4]  = mk(0, 0, 1, 0, 1);
    tv[5]  = mk(0, 1, 1, 1, 1);
    tv[6]  = mk(0, 0, 1, 0, 2);
    tv[7]  = mk(0, 0, 1, 0, 2);
    tv[8]  = mk(0, 1, 1, 0, 2);
    tv[9]  = mk(0, 1, 1, 1, 2);
    tv[10] = mk(0, 1, 1, 0, 3);
    tv[11] = mk(1, 1, 0, 0, 0);
    tv[12] = mk(0, 1, 0, 1, 0);
    tv[13] = mk(0, 1, 0, 1, 1);
    tv[14] = mk(0, 0, 0, 0, 2);
    tv[15] = mk(0, 1, 0, 1, 2);

    for (int i = 0; i < 16; i++) begin
      rst = tv[i].rst; cen = tv[i].cen; div_sel = tv[i].div_sel;
      step();
      chk($sformatf("vec%0d_cenop", i),  int'(cenop),  int'(tv[i].cenop));
      chk($sformatf("vec%0d_slot", i),   int'(slot),   int'(tv[i].slot));
      chk($sformatf("vec%0d_zero", i),   int'(zero),   int'(tv[i].zero));
      chk($sformatf("vec%0d_cenfrm", i), int'(cenfrm), int'(tv[i].cenfrm));
    end

    // Divide by 4, cen always high.
    do_reset(3'd3);
    mx = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (int'(slot) > mx) mx = int'(slot);
    end
    chk("d4_first_cenop", (q_op.size() > 0) ? q_op[0] : -1, 4);
    chk("d4_first_cenfrm", (q_frm.size() > 0) ? q_frm[0] : -1, 72);
    chk("d4_first_zero", (q_zr.size() > 0) ? q_zr[0] : -1, 73);
    chk("d4_zero_width", (q_zf.size() > 0) ? q_zf[0] - q_zr[0] : -1, 4);
    chk("d4_slot_max", mx, 17);
    chk("d4_frm_slot", (q_frm_slot.size() > 0) ? q_frm_slot[0] : -1, 17);
    tmp = q_op;  chk_iv("d4_cenop_gap", 4);
    tmp = q_frm; chk_iv("d4_cenfrm_gap", 72);
    tmp = q_zr;  chk_iv("d4_zero_gap", 72);

    // Divide by 4 with cen on alternate clks.
    do_reset(3'd3);
    for (int i = 0; i < 400; i++) begin
      cen = ~cen;
      step();
    end
    cen = 1'b1;
    chk("alt_cenop_width", dbl_cenop, 0);
    tmp = q_op;  chk_iv("alt_cenop_gap", 8);
    tmp = q_frm; chk_iv("alt_cenfrm_gap", 144);

    // Ratio change mid-frame only applies from slot 0 of the next frame.
    do_reset(3'd3);
    wait_slot(5);
    div_sel = 3'd1;
    clear();
    for (int i = 0; i < 120; i++) step();
    chk("chg_frm_seen", int'(q_frm.size() > 0), 1);
    f = (q_frm.size() > 0) ? q_frm[0] : 100000;
    n = 0;
    for (int i = 1; i < q_op.size(); i++) begin
      chk($sformatf("chg_gap%0d", i), q_op[i] - q_op[i-1], (q_op[i] <= f) ? 4 : 2);
      if (q_op[i] > f) n++;
    end
    chk("chg_after_seen", int'(n > 3), 1);

    // Divide by 1: cenop constant, slot steps every clk.
    do_reset(3'd0);
    n = 0; bad = 0; prv = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (cenop) n++;
      if (prv >= 0 && int'(slot) != (prv + 1) % 18) bad++;
      prv = int'(slot);
    end
    chk("d1_cenop_high", n, 60);
    chk("d1_slot_step_bad", bad, 0);
    chk("d1_zero_width", (q_zf.size() > 0) ? q_zf[0] - q_zr[0] : -1, 1);
    tmp = q_zr; chk_iv("d1_zero_gap", 18);

    // Reset in the middle of a frame.
    do_reset(3'd3);
    wait_slot(9);
    rst = 1'b1;
    step();
    chk("rst_outs", int'({cenop, cenfrm, zero, slot}), 0);
    rst = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!cenop && n < 20);
    chk("rst_first_cenop", n, 4);
    chk("rst_slot_at_cenop", int'(slot), 0);
    step();
    chk("rst_slot_next", int'(slot), 1);

`ifdef JTOPL_DIV_HOLD_EN
    // Freeze at slot 4 with the divider at 2.
    do_reset(3'd3);
    wait_slot(4);
    step();
    hold = 1'b1;
    clear();
    for (int i = 0; i < 10; i++) step();
    chk("hold_no_cenop", q_op.size(), 0);
    chk("hold_slot", int'(slot), 4);
    hold = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!cenop && n < 20);
    chk("hold_resume_cenop", n, 2);
    step();
    chk("hold_slot_next", int'(slot), 5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtopl_slot_div.md
JTOPL_SLOT_DIV -- requirements
Module: jtopl_slot_div

Interface
REQ-001 Parameter DIVW, default 3: width of the clock-divider counter and of div_sel.
REQ-002 Parameter OPCOUNT, default 18: number of operator slots per sample frame, legal range 2..2^SLOTW.
REQ-003 Parameter SLOTW, default 5: width of the slot output.
REQ-004 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 cen  in  1  input clock enable; the divider advances only on clk edges where cen=1.
REQ-007 div_sel  in  DIVW  requested divide ratio minus one, so the ratio is div_sel+1 (1..2^DIVW).
REQ-008 hold  in  1  freeze request; present only when JTOPL_DIV_HOLD_EN is defined.
REQ-009 cenop  out  1  one-clk pulse at operator rate.
REQ-010 zero  out  1  high for one operator period while slot 0 is current, following a wrap.
REQ-011 slot  out  SLOTW  index of the current operator slot, 0..OPCOUNT-1.
REQ-012 cenfrm  out  1  one-clk pulse at sample-frame rate, coincident with the cenop that wraps slot.

Function
REQ-013 The block SHALL hold an internal divide count cnt[DIVW-1:0] and an active ratio div_q[DIVW-1:0].
REQ-014 On cen=1 it SHALL set cnt <= (cnt==div_q) ? 0 : cnt+1; with cen=0, cnt holds.
REQ-015 cenop SHALL be registered every clk as cen && (cnt==div_q), so it lasts exactly one clk and goes low whenever cen=0.
REQ-016 On cenop=1, slot SHALL advance: slot <= (slot==OPCOUNT-1) ? 0 : slot+1.
REQ-017 On the same cenop, zero SHALL be set to (slot==OPCOUNT-1); zero SHALL hold between cenops.
REQ-018 cenfrm SHALL be registered as cen && (cnt==div_q) && (slot==OPCOUNT-1).
REQ-019 div_q SHALL load div_sel only on the clk edge that also sets cenfrm, so a ratio change never takes effect inside a frame.
REQ-020 A new ratio SHALL first apply to the divide period of slot 0 of the next frame; div_sel changes between frame boundaries SHALL be ignored except for the value sampled at the boundary.
REQ-021 With div_sel=0 (divide by 1) and cen held high, cenop SHALL be high on every clk.
REQ-022 slot SHALL never exceed OPCOUNT-1; wrap-around SHALL be exact for non-power-of-two OPCOUNT.
REQ-023 Latency: cen edge with cnt==div_q -> cenop high on the following clk -> slot/zero updated on the clk after that.

Reset
REQ-024 While rst=1: cnt=0, slot=0, zero=0, cenop=0, cenfrm=0, div_q <= div_sel.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; the first cenop after release SHALL occur after div_sel+1 cen cycles.
REQ-026 rst SHALL take priority over cen and hold.

Configuration
REQ-027 Macro JTOPL_DIV_HOLD_EN defined: the hold port exists. While hold=1, cnt, slot, zero and div_q freeze, and cenop=cenfrm=0 from the next clk. Counting SHALL resume from the frozen values when hold=0.
REQ-028 Macro JTOPL_DIV_HOLD_EN undefined: no hold port; behaviour is identical to the defined case with hold=0.

Verification
REQ-029 div_sel=3, cen=1 constantly -> cenop once every 4 clks; zero rises every 72 clks; slot walks 0..17; cenfrm with each slot 17->0 wrap.
REQ-030 div_sel=3, cen=1 on alternate clks -> cenop every 8 clks, one clk wide; cenfrm every 144 clks.
REQ-031 div_sel changed 3->1 while slot=5 -> slots 5..17 keep a 4-cen spacing; from slot 0 onward the spacing is 2 cens.
REQ-032 div_sel=0, cen=1 -> cenop constant high; slot increments every clk; zero high for 1 clk every 18.
REQ-033 rst pulsed at slot=9 -> all outputs 0 next clk; first cenop div_sel+1 cens after release; slot restarts at 0.
REQ-034 (JTOPL_DIV_HOLD_EN) hold=1 for 10 clks at slot=4, cnt=2 -> no cenop during hold; after release, slot 5 arrives after exactly 2 more cen cycles (div_sel=3).
